// File: rtl/fp_sqrt_iter_if.sv
// Operand/result handshake bundle for the iterative square-root unit.
interface fp_sqrt_iter_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         Exception;
  logic         Underflow;
  logic         Overflow;

  // Requester side: supplies operands and consumes results
  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, result, Exception, Underflow, Overflow
  );

  // Unit side
  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, result, Exception, Underflow, Overflow
  );
endinterface

// File: rtl/fp_sqrt_iter.sv
// Multi-cycle IEEE-754 square root: restoring digit-by-digit, one root bit
// per cycle, round-to-nearest-even, fixed latency of MAN_W+4 cycles.
module fp_sqrt_iter #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input logic           clk,
  input logic           rst_n,
  fp_sqrt_iter_if.slave bus
);
  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned N  = MAN_W + 2;       // root bits: implicit, fraction, guard
  localparam int unsigned RW = MAN_W + 4;       // remainder width
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned EW = EXP_W + 2;       // exponent arithmetic with sign headroom
  localparam logic [EW-1:0] Bias = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [W-1:0]  QNan = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StUnpack, StIter, StRound, StDone} state_e;

  state_e          state_q;
  logic [W-1:0]    a_q;
  logic [2*N-1:0]  rad_q;
  logic [RW-1:0]   rem_q;
  logic [N-1:0]    root_q;
  logic [CW-1:0]   cnt_q;
  logic [EW-1:0]   exp_q;
  logic            spec_q;
  logic [W-1:0]    spec_val_q;
  logic            spec_exc_q;
  logic            spec_unf_q;

  logic               sgn;
  logic [EXP_W-1:0]   ex;
  logic [MAN_W-1:0]   fr;
  assign {sgn, ex, fr} = a_q;

  // Unpack: unbias, make the exponent even, align the radicand, decode specials
  logic [EW-1:0]  e_unb;
  logic [N-1:0]   sig;
  logic [2*N-1:0] rad_init;
  logic [EW-1:0]  exp_init;
  logic           spec_d, spec_exc_d, spec_unf_d;
  logic [W-1:0]   spec_val_d;
  always_comb begin
    e_unb = {2'b00, ex} - Bias;
    sig   = {1'b0, 1'b1, fr};
    if (e_unb[0]) begin
      sig   = sig << 1;
      e_unb = e_unb - EW'(1);
    end
    rad_init = {sig, {N{1'b0}}};
    // e_unb is even here, so the arithmetic halving is exact
    exp_init = {e_unb[EW-1], e_unb[EW-1:1]} + Bias;

    spec_d     = 1'b1;
    spec_val_d = '0;
    spec_exc_d = 1'b0;
    spec_unf_d = 1'b0;
    if ((&ex) && (|fr)) begin
      spec_val_d = QNan;
      spec_exc_d = 1'b1;
    end else if (~|ex) begin
      // Zero keeps its sign; a subnormal of either sign flushes to signed zero
      spec_val_d = {sgn, {(W-1){1'b0}}};
      spec_unf_d = |fr;
    end else if (sgn) begin
      spec_val_d = QNan;
      spec_exc_d = 1'b1;
    end else if (&ex) begin
      spec_val_d = a_q;
    end else begin
      spec_d = 1'b0;
    end
  end

  // One restoring step: bring down two radicand bits, try subtracting 4r+1
  logic [RW-1:0] rem_sh, trial, rem_nx;
  logic [N-1:0]  root_nx;
  logic          ge;
  always_comb begin
    rem_sh  = {rem_q[RW-3:0], rad_q[2*N-1:2*N-2]};
    trial   = {root_q, 2'b01};
    ge      = (rem_sh >= trial);
    rem_nx  = ge ? (rem_sh - trial) : rem_sh;
    root_nx = {root_q[N-2:0], ge};
  end

  // Round to nearest even on the guard bit, remainder gives the sticky
  logic              inc;
  logic [MAN_W+1:0]  mant_r;
  logic [EW-1:0]     exp_r;
  logic [MAN_W-1:0]  frac_r;
  logic [W-1:0]      norm_res;
  logic              unused_exp_bits;
  always_comb begin
    inc    = root_q[0] & ((|rem_q) | root_q[1]);
    mant_r = {1'b0, root_q[N-1:1]} + (MAN_W+2)'(inc);
    if (mant_r[MAN_W+1]) begin
      exp_r  = exp_q + EW'(1);
      frac_r = mant_r[MAN_W:1];
    end else begin
      exp_r  = exp_q;
      frac_r = mant_r[MAN_W-1:0];
    end
    norm_res = {1'b0, exp_r[EXP_W-1:0], frac_r};
  end
  assign unused_exp_bits = ^exp_r[EW-1:EXP_W];

  assign bus.Overflow = 1'b0;

  // Operation sequencing, datapath state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      a_q           <= '0;
      rad_q         <= '0;
      rem_q         <= '0;
      root_q        <= '0;
      cnt_q         <= '0;
      exp_q         <= '0;
      spec_q        <= 1'b0;
      spec_val_q    <= '0;
      spec_exc_q    <= 1'b0;
      spec_unf_q    <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.Exception <= 1'b0;
      bus.Underflow <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid && bus.in_ready) begin
            a_q          <= bus.a;
            bus.in_ready <= 1'b0;
            state_q      <= StUnpack;
          end
        end
        StUnpack: begin
          rad_q      <= rad_init;
          rem_q      <= '0;
          root_q     <= '0;
          cnt_q      <= '0;
          exp_q      <= exp_init;
          spec_q     <= spec_d;
          spec_val_q <= spec_val_d;
          spec_exc_q <= spec_exc_d;
          spec_unf_q <= spec_unf_d;
          state_q    <= StIter;
        end
        StIter: begin
          rad_q  <= {rad_q[2*N-3:0], 2'b00};
          rem_q  <= rem_nx;
          root_q <= root_nx;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) state_q <= StRound;
        end
        StRound: begin
          bus.out_valid <= 1'b1;
          bus.result    <= spec_q ? spec_val_q : norm_res;
          bus.Exception <= spec_q & spec_exc_q;
          bus.Underflow <= spec_q & spec_unf_q;
          state_q       <= StDone;
        end
        StDone: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.Exception <= 1'b0;
            bus.Underflow <= 1'b0;
            bus.in_ready  <= 1'b1;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Directed bench for fp_sqrt_iter: single precision plus a half-precision instance.
module tb_fp_sqrt_iter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fp_sqrt_iter_if #(.EXP_W(8), .MAN_W(23)) b32 ();
  fp_sqrt_iter_if #(.EXP_W(5), .MAN_W(10)) b16 ();

  fp_sqrt_iter #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  fp_sqrt_iter #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  localparam logic [31:0] SpIn  [6] = '{32'hC0800000, 32'h80000000, 32'h7F800000,
                                        32'h7FC00001, 32'h00000001, 32'hFF800000};
  localparam logic [31:0] SpOut [6] = '{32'h7FC00000, 32'h80000000, 32'h7F800000,
                                        32'h7FC00000, 32'h00000000, 32'h7FC00000};
  // {Exception, Underflow, Overflow}
  localparam logic [2:0]  SpFlg [6] = '{3'b100, 3'b000, 3'b000, 3'b100, 3'b010, 3'b100};

  // Issue one operand and wait for its result; called #1 after a rising edge
  task automatic op32(input logic [31:0] val, input bit take, output logic [31:0] res,
                      output logic [2:0] flg, output int lat);
    int wt = 0;
    b32.a = val;
    b32.in_valid = 1'b1;
    while (b32.in_ready !== 1'b1 && wt < 100) begin @(posedge clk); #1; wt++; end
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    lat = 0;
    while (b32.out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    res = b32.result;
    flg = {b32.Exception, b32.Underflow, b32.Overflow};
    if (take) begin
      b32.out_ready = 1'b1;
      @(posedge clk); #1;
      b32.out_ready = 1'b0;
    end
  endtask

  task automatic op16(input logic [15:0] val, output logic [15:0] res,
                      output logic [2:0] flg, output int lat);
    int wt = 0;
    b16.a = val;
    b16.in_valid = 1'b1;
    while (b16.in_ready !== 1'b1 && wt < 100) begin @(posedge clk); #1; wt++; end
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
    lat = 0;
    while (b16.out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    res = b16.result;
    flg = {b16.Exception, b16.Underflow, b16.Overflow};
    b16.out_ready = 1'b1;
    @(posedge clk); #1;
    b16.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({b32.in_ready, b32.out_valid, b32.Exception, b32.Underflow, b32.Overflow} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl32: got %b expected %b", {b32.in_ready, b32.out_valid,
               b32.Exception, b32.Underflow, b32.Overflow}, 5'b10000);
    end
    n_checks++;
    if (b32.result !== 32'h0) begin
      n_fail++; $display("FAIL reset_result32: got %h expected %h", b32.result, 32'h0);
    end
    n_checks++;
    if ({b16.in_ready, b16.out_valid, b16.result} !== {2'b10, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_16: got %b/%b/%h expected 1/0/0000", b16.in_ready, b16.out_valid, b16.result);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_exact;
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    op32(32'h40800000, 1'b1, r, f, lat);
    n_checks++;
    if (r !== 32'h40000000) begin
      n_fail++; $display("FAIL sqrt4_result: got %h expected %h", r, 32'h40000000);
    end
    n_checks++;
    if (f !== 3'b000) begin n_fail++; $display("FAIL sqrt4_flags: got %b expected 000", f); end
    n_checks++;
    if (lat != 27) begin n_fail++; $display("FAIL sqrt4_latency: got %0d expected 27", lat); end
    n_checks++;
    if ({b32.in_ready, b32.out_valid, b32.result} !== {2'b10, 32'h0}) begin
      n_fail++;
      $display("FAIL clear_after_take: got %b/%b/%h expected 1/0/00000000",
               b32.in_ready, b32.out_valid, b32.result);
    end
    op32(32'h44D22000, 1'b1, r, f, lat);
    n_checks++;
    if (r !== 32'h42240000 || f !== 3'b000) begin
      n_fail++; $display("FAIL sqrt1681: got %h/%b expected 42240000/000", r, f);
    end
  endtask

  task automatic test_rounding;
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    op32(32'h40000000, 1'b1, r, f, lat);
    n_checks++;
    if (r !== 32'h3FB504F3) begin
      n_fail++; $display("FAIL sqrt2_result: got %h expected %h", r, 32'h3FB504F3);
    end
    op32(32'h3F800000, 1'b1, r, f, lat);
    n_checks++;
    if (r !== 32'h3F800000 || f !== 3'b000) begin
      n_fail++; $display("FAIL sqrt1: got %h/%b expected 3f800000/000", r, f);
    end
  endtask

  task automatic test_specials;
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      op32(SpIn[i], 1'b1, r, f, lat);
      n_checks++;
      if (r !== SpOut[i]) begin
        n_fail++; $display("FAIL special_result[%0d]: got %h expected %h", i, r, SpOut[i]);
      end
      n_checks++;
      if (f !== SpFlg[i]) begin
        n_fail++; $display("FAIL special_flags[%0d]: got %b expected %b", i, f, SpFlg[i]);
      end
      n_checks++;
      if (lat != 27) begin
        n_fail++; $display("FAIL special_latency[%0d]: got %0d expected 27", i, lat);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    op32(32'h40000000, 1'b0, r, f, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({b32.out_valid, b32.in_ready, b32.result} !== {2'b10, 32'h3FB504F3}) begin
        n_fail++;
        $display("FAIL hold[%0d]: got %b/%b/%h expected 1/0/3fb504f3",
                 i, b32.out_valid, b32.in_ready, b32.result);
      end
    end
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    b32.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    op32(32'h40800000, 1'b0, r, f, lat);
    n_checks++;
    if (r !== 32'h40000000) begin
      n_fail++; $display("FAIL b2b_first: got %h expected 40000000", r);
    end
    // Take the result while presenting the next operand on the same edge
    b32.a = 32'h44D22000;
    b32.in_valid  = 1'b1;
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    b32.out_ready = 1'b0;
    n_checks++;
    if ({b32.in_ready, b32.out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_not_accepted_on_take: got %b%b expected 10", b32.in_ready, b32.out_valid);
    end
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    n_checks++;
    if (b32.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept_next: got in_ready=%b expected 0", b32.in_ready);
    end
    lat = 0;
    while (b32.out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (lat != 27 || b32.result !== 32'h42240000) begin
      n_fail++; $display("FAIL b2b_second: got %h lat %0d expected 42240000 lat 27", b32.result, lat);
    end
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    b32.out_ready = 1'b0;
  endtask

  task automatic test_mid_reset;
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    bit          saw;
    b32.a = 32'h44D22000;
    b32.in_valid = 1'b1;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({b32.in_ready, b32.out_valid, b32.result, b32.Exception, b32.Underflow} !== {2'b10, 32'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b/%b/%h expected 1/0/00000000",
               b32.in_ready, b32.out_valid, b32.result);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (b32.out_valid !== 1'b0) saw = 1'b1;
    end
    n_checks++;
    if (saw) begin n_fail++; $display("FAIL midreset_stale_valid: got 1 expected 0"); end
    op32(32'h40800000, 1'b1, r, f, lat);
    n_checks++;
    if (r !== 32'h40000000 || lat != 27) begin
      n_fail++; $display("FAIL midreset_recover: got %h lat %0d expected 40000000 lat 27", r, lat);
    end
  endtask

  task automatic test_half;
    logic [15:0] r;
    logic [2:0]  f;
    int          lat;
    op16(16'h4400, r, f, lat);
    n_checks++;
    if (r !== 16'h4000 || f !== 3'b000) begin
      n_fail++; $display("FAIL half_sqrt4: got %h/%b expected 4000/000", r, f);
    end
    n_checks++;
    if (lat != 14) begin n_fail++; $display("FAIL half_latency: got %0d expected 14", lat); end
    op16(16'hC400, r, f, lat);
    n_checks++;
    if (r !== 16'h7E00 || f !== 3'b100) begin
      n_fail++; $display("FAIL half_neg: got %h/%b expected 7e00/100", r, f);
    end
  endtask

  initial begin
    b32.in_valid = 1'b0; b32.out_ready = 1'b0; b32.a = '0;
    b16.in_valid = 1'b0; b16.out_ready = 1'b0; b16.a = '0;
    test_reset();
    test_exact();
    test_rounding();
    test_specials();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_half();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
